// File: rtl/modport_device_pkg.sv
// modport_device_pkg: shared response type and sizing helper for the Wishbone FIFO endpoint
package modport_device_pkg;

    typedef enum logic [1:0] {
        RESP_NONE,
        RESP_ACK,
        RESP_ERR,
        RESP_RTY
    } resp_t;

    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/modport_device_fifo.sv
// modport_device_fifo: synchronous FIFO with extra level bit so full and empty are distinct
module modport_device_fifo
    import modport_device_pkg::*;
#(
    parameter int DAT_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DAT_WIDTH-1:0]     din,
    output logic [DAT_WIDTH-1:0]     dout,
    output logic                     full,
    output logic                     empty,
    output logic [lvl_w(DEPTH)-1:0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [DAT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr;
    logic [AW-1:0]        rd_ptr;

    assign dout  = mem[rd_ptr];
    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;

    // storage and pointers; cleared storage keeps the head word at zero out of reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(push) - LW'(pop);
        end
    end

endmodule

// File: rtl/modport_device.sv
// modport_device: Wishbone Classic write-only device feeding a valid/ready stream through a FIFO.
// Define MODPORT_DEVICE_ERR_EN to terminate reads with err_o instead of ack_o.
module modport_device
    import modport_device_pkg::*;
#(
    parameter int DAT_WIDTH = 8,
    parameter int DEPTH     = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     cyc_i,
    input  logic                     stb_i,
    input  logic                     we_i,
    input  logic [DAT_WIDTH-1:0]     dat_i,
    output logic                     ack_o,
    output logic                     err_o,
    output logic                     rty_o,
    output logic                     m_valid_o,
    output logic [DAT_WIDTH-1:0]     m_data_o,
    input  logic                     m_ready_i,
    output logic [lvl_w(DEPTH)-1:0]  level_o
);

    resp_t resp;
    resp_t resp_nxt;
    resp_t rd_resp;
    logic  accept;
    logic  full;
    logic  empty;
    logic  push;
    logic  pop;

`ifdef MODPORT_DEVICE_ERR_EN
    assign rd_resp = RESP_ERR;
    assign err_o   = resp == RESP_ERR;
`else
    assign rd_resp = RESP_ACK;
    assign err_o   = 1'b0;
`endif

    // a termination cycle blocks acceptance, giving one transfer per two cycles
    assign accept    = cyc_i & stb_i & (resp == RESP_NONE);
    assign push      = accept & we_i & ~full;
    assign pop       = ~empty & m_ready_i;
    assign ack_o     = resp == RESP_ACK;
    assign rty_o     = resp == RESP_RTY;
    assign m_valid_o = ~empty;

    // response decision uses the pre-edge level, so a simultaneous pop never rescues a full write
    always_comb begin
        resp_nxt = RESP_NONE;
        resp_nxt = !accept ? RESP_NONE : !we_i ? rd_resp : full ? RESP_RTY : RESP_ACK;
    end

    // one-cycle registered termination
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) resp <= RESP_NONE;
        else       resp <= resp_nxt;
    end

    modport_device_fifo #(
        .DAT_WIDTH (DAT_WIDTH),
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (push),
        .pop   (pop),
        .din   (dat_i),
        .dout  (m_data_o),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

endmodule

// File: tb/tb_modport_device.sv
// tb_modport_device: randomized and directed checks of modport_device against a queue model
module tb_modport_device;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          cyc_i = 1'b0;
    logic          stb_i = 1'b0;
    logic          we_i = 1'b0;
    logic [DW-1:0] dat_i = '0;
    logic          m_ready_i = 1'b0;
    logic          ack_o;
    logic          err_o;
    logic          rty_o;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic [2:0]    level_o;

    int n_checks = 0;
    int n_fail   = 0;

    // model: 0 none, 1 ack, 2 err, 3 retry
    logic [DW-1:0] q[$];
    int            exp_resp = 0;

    modport_device #(.DAT_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .cyc_i     (cyc_i),
        .stb_i     (stb_i),
        .we_i      (we_i),
        .dat_i     (dat_i),
        .ack_o     (ack_o),
        .err_o     (err_o),
        .rty_o     (rty_o),
        .m_valid_o (m_valid_o),
        .m_data_o  (m_data_o),
        .m_ready_i (m_ready_i),
        .level_o   (level_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("ack", 32'(ack_o), 32'(exp_resp == 1));
        check("err", 32'(err_o), 32'(exp_resp == 2));
        check("rty", 32'(rty_o), 32'(exp_resp == 3));
        check("valid", 32'(m_valid_o), 32'(q.size() != 0));
        check("level", 32'(level_o), 32'(q.size()));
        if (q.size() != 0) check("data", 32'(m_data_o), 32'(q[0]));
    endtask

    // called at a negedge: drive inputs, advance model across the next posedge, then check
    task automatic step(input logic c, input logic s, input logic w, input logic [DW-1:0] d, input logic r);
        bit acc;
        bit was_full;
        bit do_pop;
        cyc_i = c; stb_i = s; we_i = w; dat_i = d; m_ready_i = r;
        acc      = c && s && exp_resp == 0;
        was_full = q.size() == DEPTH;
        do_pop   = q.size() != 0 && r;
`ifdef MODPORT_DEVICE_ERR_EN
        exp_resp = !acc ? 0 : !w ? 2 : was_full ? 3 : 1;
`else
        exp_resp = !acc ? 0 : !w ? 1 : was_full ? 3 : 1;
`endif
        if (do_pop) void'(q.pop_front());
        if (acc && w && !was_full) q.push_back(d);
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs();
    endtask

    task automatic idle(input logic r);
        step(1'b0, 1'b0, 1'b0, '0, r);
    endtask

    task automatic async_reset();
        #2 rst_i = 1'b1;
        #1;
        q.delete();
        exp_resp = 0;
        check("rst_ack", 32'(ack_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_rty", 32'(rty_o), 0);
        check("rst_valid", 32'(m_valid_o), 0);
        check("rst_level", 32'(level_o), 0);
        check("rst_data", 32'(m_data_o), 0);
        cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; m_ready_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        async_reset();
        idle(1'b0);
        // single write
        step(1'b1, 1'b1, 1'b1, 8'hA5, 1'b0);
        idle(1'b0);
        // reset during a response cycle drops the ack and the FIFO
        step(1'b1, 1'b1, 1'b1, 8'h3C, 1'b0);
        async_reset();
        // fill then overflow
        for (int i = 1; i <= 5; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'(i), 1'b0);
            idle(1'b0);
        end
        // full write with simultaneous pop still retries
        step(1'b1, 1'b1, 1'b1, 8'h06, 1'b1);
        idle(1'b0);
        // read has no side effect
        step(1'b1, 1'b1, 1'b0, 8'h77, 1'b0);
        idle(1'b0);
        // held strobe: one transfer per two cycles
        repeat (4) step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
        // drain and stream across pointer wrap
        repeat (4) idle(1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 1'b1, 8'(i), 1'b1);
            idle(1'b1);
        end
        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 4) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0));
            if (i == 300) async_reset();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
